my_master: RTL

MY_MASTER -- requirements
Module: my_master

---
 rtl/my_master.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/my_master.sv
// my_master: byte-stream to Avalon-MM write master.
// Incoming bytes are queued in a small FIFO and written out one per transfer
// to an auto-incrementing address, honouring the slave's waitrequest.
module my_master #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          DEPTH     = 4
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [7:0]        coe_m0_din,
  input  logic              coe_m0_valid,
  output logic              coe_m0_ready,
  input  logic              coe_m0_clr,
  output logic              coe_m0_busy,
  output logic [7:0]        coe_m0_wcount,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_write,
  output logic [7:0]        avm_m0_writedata,
  input  logic              avm_m0_waitrequest
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [0:0]        state_q,    state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0] address_q,  address_d;
  logic [7:0]        wdata_q,    wdata_d;
  logic [7:0]        wcount_q,   wcount_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic wr_done;
  logic clr_ok;
  logic [7:0] head;

  // Handshake decode; ready depends only on the registered occupancy.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    head       = mem_q[rd_ptr_q];
    push       = coe_m0_valid & ~fifo_full;
    wr_done    = (state_q == S_WRITE) & ~avm_m0_waitrequest;
    pop        = ~fifo_empty & ((state_q == S_IDLE) | wr_done);
    clr_ok     = coe_m0_clr & (state_q == S_IDLE) & fifo_empty;
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = coe_m0_din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Write FSM, address counter and completed-write counter.
  // Clear can only be accepted when idle and empty, so it never collides with
  // a pop; a simultaneous push is stored normally and later goes to BASE.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    wcount_d   = wcount_q;
    if (clr_ok) begin
      addr_cnt_d = BASE;
      wcount_d   = '0;
    end
    if (state_q == S_IDLE) begin
      if (!fifo_empty) begin
        state_d   = S_WRITE;
        address_d = addr_cnt_q;
        wdata_d   = head;
      end
    end else begin
      if (wr_done) begin
        addr_cnt_d = addr_cnt_q + 1'b1;
        wcount_d   = wcount_q + 1'b1;
        if (!fifo_empty) begin
          address_d = addr_cnt_q + 1'b1;
          wdata_d   = head;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      addr_cnt_q <= BASE;
      address_q  <= BASE;
      wdata_q    <= '0;
      wcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      addr_cnt_q <= addr_cnt_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      wcount_q   <= wcount_d;
    end
  end

  // FIFO data array; contents are don't-care while occupancy is zero.
  always_ff @(posedge csi_clk) begin
    mem_q <= mem_d;
  end

  // Output drive, all from registers.
  always_comb begin
    coe_m0_ready     = ~fifo_full;
    coe_m0_busy      = (state_q == S_WRITE) | ~fifo_empty;
    coe_m0_wcount    = wcount_q;
    avm_m0_address   = address_q;
    avm_m0_write     = (state_q == S_WRITE);
    avm_m0_writedata = wdata_q;
  end

endmodule
